// File: rtl/bist_engine.sv
// BIST wrapper: LFSR stimulus, MISR compaction and a sequencing FSM around one CUT.
// Functional mode is a zero-latency passthrough; a run ends with a held bist_end/pass_fail.
module bist_engine #(
    parameter int                IN_W       = 4,
    parameter int                OUT_W      = 4,
    parameter logic [IN_W-1:0]   LFSR_POLY  = 4'b1001,
    parameter logic [IN_W-1:0]   LFSR_SEED  = 4'b0001,
    parameter logic [OUT_W-1:0]  MISR_POLY  = 4'b1001,
    parameter int                N_PATTERNS = 1000,
    parameter int                LATENCY    = 0,
    parameter int                RST_CYCLES = 2,
    parameter logic [OUT_W-1:0]  GOLDEN     = 4'h0,
    parameter int                CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IN_W-1:0]  func_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic [IN_W-1:0]  cut_in,
    output logic             cut_reset,
    output logic [OUT_W-1:0] func_out,
    output logic             test_mode,
    output logic             bist_end,
    output logic             pass_fail,
    output logic [OUT_W-1:0] signature
);

    typedef enum logic [2:0] {
        S_IDLE, S_CUT_RST, S_RUN, S_FLUSH, S_COMPARE, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(N_PATTERNS + LATENCY - 1);
    localparam state_t           AFTER_RUN  = (LATENCY > 0) ? S_FLUSH : S_COMPARE;

    state_t             state_q;
    logic               start_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IN_W-1:0]    lfsr_q, lfsr_d;
    logic [OUT_W-1:0]   misr_q, misr_d;
    logic               test_mode_q, bist_end_q, pass_fail_q;
    logic               start_rise, lat_ok, compact, idle_like;

    // cnt_q counts from RUN start through FLUSH, so the latency window is one compare
    if (LATENCY == 0) begin : g_nolat
        assign lat_ok = 1'b1;
    end else begin : g_lat
        assign lat_ok = (cnt_q >= CNT_W'(LATENCY));
    end

    assign start_rise = start & ~start_q;
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign compact    = ((state_q == S_RUN) || (state_q == S_FLUSH)) && lat_ok;
    assign lfsr_d     = (lfsr_q == '0) ? LFSR_SEED
                                       : {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_POLY)};
    assign misr_d     = {misr_q[OUT_W-2:0], ^(misr_q & MISR_POLY)} ^ cut_out;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            misr_q      <= '0;
            test_mode_q <= 1'b0;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
        end else begin
            start_q <= start;
            if ((state_q == S_RUN) || (lfsr_q == '0))
                lfsr_q <= lfsr_d;
            if (compact)
                misr_q <= misr_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_rise) begin
                        state_q     <= S_CUT_RST;
                        cnt_q       <= '0;
                        lfsr_q      <= LFSR_SEED;
                        misr_q      <= '0;
                        test_mode_q <= 1'b1;
                        bist_end_q  <= 1'b0;
                        pass_fail_q <= 1'b0;
                    end
                end
                S_CUT_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == RUN_LAST)
                        state_q <= AFTER_RUN;
                end
                S_FLUSH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == FLUSH_LAST)
                        state_q <= S_COMPARE;
                end
                S_COMPARE: begin
                    pass_fail_q <= (misr_q == GOLDEN);
                    bist_end_q  <= 1'b1;
                    test_mode_q <= 1'b0;
                    state_q     <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cut_in    = idle_like ? func_in : ((state_q == S_RUN) ? lfsr_q : '0);
    assign cut_reset = reset & (state_q != S_CUT_RST);
    assign func_out  = cut_out;
    assign test_mode = test_mode_q;
    assign bist_end  = bist_end_q;
    assign pass_fail = pass_fail_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench: three engines (3-pattern loopback, 15-pattern LFSR walk, 2-cycle-latency CUT).
module tb_bist_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] func_in;
    logic       start_a, start_b, start_c;
    logic       stuck_a;
    int         n_checks = 0;
    int         n_err    = 0;
    int         n;

    logic [3:0] cut_in_a, cut_out_a, func_out_a, sig_a;
    logic       cut_reset_a, test_mode_a, bist_end_a, pass_fail_a;
    logic [3:0] cut_in_b, cut_out_b, func_out_b, sig_b;
    logic       cut_reset_b, test_mode_b, bist_end_b, pass_fail_b;
    logic [3:0] cut_in_c, cut_out_c, func_out_c, sig_c;
    logic       cut_reset_c, test_mode_c, bist_end_c, pass_fail_c;
    logic [3:0] pipe1 = 4'h0;
    logic [3:0] pipe2 = 4'h0;
    logic [3:0] lfsr_exp [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                  4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    always #5 clock = ~clock;

    // bit0 is 1 in all of 1,3,7, so the fault is planted on bit3 to be observable
    assign cut_out_a = stuck_a ? (cut_in_a | 4'b1000) : cut_in_a;
    assign cut_out_b = cut_in_b;
    always @(posedge clock) begin
        pipe1 <= cut_in_c;
        pipe2 <= pipe1;
    end
    assign cut_out_c = pipe2;

    bist_engine #(.N_PATTERNS(3), .LATENCY(0), .GOLDEN(4'h7)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .func_in(func_in),
        .cut_out(cut_out_a), .cut_in(cut_in_a), .cut_reset(cut_reset_a),
        .func_out(func_out_a), .test_mode(test_mode_a), .bist_end(bist_end_a),
        .pass_fail(pass_fail_a), .signature(sig_a));

    bist_engine #(.N_PATTERNS(15), .LATENCY(0)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .func_in(func_in),
        .cut_out(cut_out_b), .cut_in(cut_in_b), .cut_reset(cut_reset_b),
        .func_out(func_out_b), .test_mode(test_mode_b), .bist_end(bist_end_b),
        .pass_fail(pass_fail_b), .signature(sig_b));

    bist_engine #(.N_PATTERNS(3), .LATENCY(2), .GOLDEN(4'h7)) u_c (
        .clock(clock), .reset(reset), .start(start_c), .func_in(func_in),
        .cut_out(cut_out_c), .cut_in(cut_in_c), .cut_reset(cut_reset_c),
        .func_out(func_out_c), .test_mode(test_mode_c), .bist_end(bist_end_c),
        .pass_fail(pass_fail_c), .signature(sig_c));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        stuck_a = 1'b0; func_in = 4'h5;
        tick(); tick();
        chk("rst_cut_reset", cut_reset_a, 0);
        chk("rst_test_mode", test_mode_a, 0);
        chk("rst_bist_end", bist_end_a, 0);
        chk("rst_pass_fail", pass_fail_a, 0);
        chk("rst_signature", sig_a, 0);

        // functional passthrough
        reset = 1'b1; func_in = 4'hA;
        #1;
        chk("func_cut_in", cut_in_a, 4'hA);
        chk("func_cut_reset", cut_reset_a, 1);
        chk("func_out", func_out_a, 4'hA);
        tick();
        chk("func_test_mode", test_mode_a, 0);
        chk("func_bist_end", bist_end_a, 0);
        chk("func_pass_fail", pass_fail_a, 0);

        // signature pass: start sampled at edge 0
        start_a = 1'b1;
        tick();
        chk("pass_cutrst_e0", cut_reset_a, 0);
        chk("pass_tmode_e0", test_mode_a, 1);
        chk("pass_cutin_e0", cut_in_a, 0);
        tick();
        chk("pass_cutrst_e1", cut_reset_a, 0);
        tick();
        chk("pass_cutrst_e2", cut_reset_a, 1);
        chk("pass_pat0", cut_in_a, 4'h1);
        tick();
        chk("pass_sig0", sig_a, 4'h1);
        chk("pass_pat1", cut_in_a, 4'h3);
        tick();
        chk("pass_sig1", sig_a, 4'h0);
        chk("pass_pat2", cut_in_a, 4'h7);
        tick();
        chk("pass_sig2", sig_a, 4'h7);
        chk("pass_end_cmp", bist_end_a, 0);
        tick();
        chk("pass_bist_end", bist_end_a, 1);
        chk("pass_pass_fail", pass_fail_a, 1);
        chk("pass_tmode_done", test_mode_a, 0);
        chk("pass_cutin_done", cut_in_a, 4'hA);

        // start held high through DONE must not retrigger
        repeat (6) tick();
        chk("hold_tmode", test_mode_a, 0);
        chk("hold_bist_end", bist_end_a, 1);
        chk("hold_pass_fail", pass_fail_a, 1);
        start_a = 1'b0;
        tick();

        // signature fail with cut_out bit3 stuck at 1
        stuck_a = 1'b1; start_a = 1'b1;
        tick();
        chk("fail_end_clr", bist_end_a, 0);
        chk("fail_pf_clr", pass_fail_a, 0);
        start_a = 1'b0;
        n = 0;
        while (!bist_end_a && n < 40) begin tick(); n++; end
        chk("fail_bist_end", bist_end_a, 1);
        chk("fail_sig", sig_a, 4'hD);
        chk("fail_pass_fail", pass_fail_a, 0);
        stuck_a = 1'b0;

        // full LFSR walk
        start_b = 1'b1;
        repeat (3) tick();
        start_b = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("lfsr_pat%0d", i), cut_in_b, lfsr_exp[i]);
            tick();
        end
        chk("lfsr_end_cmp", bist_end_b, 0);
        tick();
        chk("lfsr_bist_end", bist_end_b, 1);

        // latency 2: two FLUSH cycles drive zeros while the MISR keeps compacting
        start_c = 1'b1;
        repeat (3) tick();
        start_c = 1'b0;
        tick(); tick();
        chk("lat_pat2", cut_in_c, 4'h7);
        chk("lat_sig_pre", sig_c, 4'h0);
        tick();
        chk("lat_flush0_in", cut_in_c, 4'h0);
        chk("lat_flush0_tm", test_mode_c, 1);
        chk("lat_sig0", sig_c, 4'h1);
        tick();
        chk("lat_flush1_in", cut_in_c, 4'h0);
        chk("lat_flush1_tm", test_mode_c, 1);
        chk("lat_sig1", sig_c, 4'h0);
        tick();
        chk("lat_sig2", sig_c, 4'h7);
        chk("lat_end_cmp", bist_end_c, 0);
        tick();
        chk("lat_bist_end", bist_end_c, 1);
        chk("lat_pass_fail", pass_fail_c, 1);

        // reset during RUN aborts the run
        start_a = 1'b1;
        repeat (4) tick();
        start_a = 1'b0;
        chk("abort_mid_sig", sig_a, 4'h1);
        chk("abort_mid_tm", test_mode_a, 1);
        reset = 1'b0;
        tick();
        chk("abort_tm", test_mode_a, 0);
        chk("abort_bist_end", bist_end_a, 0);
        chk("abort_sig", sig_a, 4'h0);
        chk("abort_cut_in", cut_in_a, 4'hA);
        chk("abort_cut_reset", cut_reset_a, 0);
        reset = 1'b1;
        tick();
        chk("abort_idle_end", bist_end_a, 0);

        // fresh run after the abort
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!bist_end_a && n < 40) begin tick(); n++; end
        chk("rerun_bist_end", bist_end_a, 1);
        chk("rerun_pass_fail", pass_fail_a, 1);
        chk("rerun_sig", sig_a, 4'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
